// File: rtl/pixel_word_adapter.sv
// pixel_word_adapter: 16-bit pixel reads served from a one-word cache over a 32-bit memory port.
module pixel_word_adapter #(
    parameter bit HALF_SEL_HI_FIRST = 1'b0
) (
    input  logic        sys_clk_clk,
    input  logic        sys_reset_reset_n,
    input  logic [31:0] s_address,
    input  logic        s_read,
    input  logic        s_lock,
    output logic        s_waitrequest,
    output logic [15:0] s_readdata,
    output logic        s_readdatavalid,
    output logic [31:0] m_address,
    output logic        m_read,
    input  logic        m_waitrequest,
    input  logic [31:0] m_readdata,
    input  logic        m_readdatavalid,
    input  logic        flush,
    output logic [15:0] miss_count
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;
    state_e      state_q, state_d;
    logic        valid_q, valid_d;
    logic [29:0] tag_q, tag_d;
    logic [31:0] data_q, data_d;
    logic [15:0] miss_q, miss_d;
    logic [15:0] rdata_q, rdata_d;
    logic        rvalid_q, rvalid_d;
    logic        hit;
    logic        unused_ok;
    assign unused_ok = ^{s_lock, s_address[0]};
    assign hit = valid_q && (s_address[31:2] == tag_q);
    assign m_address = {tag_q, 2'b00};
    assign s_readdata = rdata_q;
    assign s_readdatavalid = rvalid_q;
    assign miss_count = miss_q;
    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        tag_d = tag_q;
        data_d = data_q;
        miss_d = miss_q;
        rdata_d = rdata_q;
        rvalid_d = 1'b0;
        s_waitrequest = 1'b1;
        m_read = 1'b0;
        case (state_q)
            IDLE: begin
                s_waitrequest = s_read && !hit;
                if (s_read && hit) begin
                    rvalid_d = 1'b1;
                    rdata_d = (s_address[1] ^ HALF_SEL_HI_FIRST) ? data_q[31:16] : data_q[15:0];
                end else if (s_read) begin
                    tag_d = s_address[31:2];
                    valid_d = 1'b0;
                    state_d = REQ;
                    miss_d = (miss_q == 16'hFFFF) ? miss_q : miss_q + 16'd1;
                end
            end
            REQ: begin
                m_read = 1'b1;
                state_d = m_waitrequest ? REQ : WAIT;
            end
            WAIT: begin
                if (m_readdatavalid) begin
                    data_d = m_readdata;
                    valid_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // flush beats a same-cycle fill, so the held read misses and refetches
        if (flush) valid_d = 1'b0;
        if (!sys_reset_reset_n) s_waitrequest = 1'b0;
    end
    always_ff @(posedge sys_clk_clk or negedge sys_reset_reset_n) begin
        if (!sys_reset_reset_n) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            tag_q <= '0;
            data_q <= '0;
            miss_q <= '0;
            rdata_q <= '0;
            rvalid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            tag_q <= tag_d;
            data_q <= data_d;
            miss_q <= miss_d;
            rdata_q <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end
endmodule

// File: tb/tb_pixel_word_adapter.sv
// tb_pixel_word_adapter: directed checks of pixel_word_adapter, with a second instance using swapped halves.
module tb_pixel_word_adapter;
    logic        clk = 1'b0;
    logic        rst_n, s_read, s_lock, m_waitrequest, m_readdatavalid, flush;
    logic [31:0] s_address, m_readdata;
    logic        s_waitrequest, s_readdatavalid, m_read;
    logic [15:0] s_readdata, miss_count;
    logic [31:0] m_address;
    logic        s_waitrequest1, s_readdatavalid1, m_read1;
    logic [15:0] s_readdata1, miss_count1;
    logic [31:0] m_address1;
    int tests = 0;
    int fails = 0;
    int mcmds = 0;

    pixel_word_adapter #(.HALF_SEL_HI_FIRST(1'b0)) dut (
        .sys_clk_clk(clk), .sys_reset_reset_n(rst_n), .s_address(s_address), .s_read(s_read),
        .s_lock(s_lock), .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
        .s_readdatavalid(s_readdatavalid), .m_address(m_address), .m_read(m_read),
        .m_waitrequest(m_waitrequest), .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid),
        .flush(flush), .miss_count(miss_count)
    );

    pixel_word_adapter #(.HALF_SEL_HI_FIRST(1'b1)) dut1 (
        .sys_clk_clk(clk), .sys_reset_reset_n(rst_n), .s_address(s_address), .s_read(s_read),
        .s_lock(s_lock), .s_waitrequest(s_waitrequest1), .s_readdata(s_readdata1),
        .s_readdatavalid(s_readdatavalid1), .m_address(m_address1), .m_read(m_read1),
        .m_waitrequest(m_waitrequest), .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid),
        .flush(flush), .miss_count(miss_count1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (m_read && !m_waitrequest) mcmds <= mcmds + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_miss(input logic [31:0] a, input logic [31:0] d, input logic [15:0] e0, input logic [15:0] e1);
        s_address = a;
        s_read = 1'b1;
        tick;
        tick;
        m_readdata = d;
        m_readdatavalid = 1'b1;
        tick;
        m_readdatavalid = 1'b0;
        tick;
        chk("sat_rvalid", 32'(s_readdatavalid), 1);
        chk("sat_rdata", 32'(s_readdata), 32'(e0));
        chk("sat_rdata_swap", 32'(s_readdata1), 32'(e1));
        chk("sat_count", 32'(miss_count), 32'hFFFF);
        s_read = 1'b0;
        tick;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; s_read = 1'b1; s_lock = 1'b0; m_waitrequest = 1'b0;
        m_readdatavalid = 1'b0; flush = 1'b0; s_address = 32'h2; m_readdata = '0;
        tick;
        chk("rst_swait", 32'(s_waitrequest), 0);
        chk("rst_mread", 32'(m_read), 0);
        chk("rst_rvalid", 32'(s_readdatavalid), 0);
        chk("rst_rdata", 32'(s_readdata), 0);
        chk("rst_count", 32'(miss_count), 0);
        s_read = 1'b0;
        tick;
        rst_n = 1'b1;
        tick;
        // cold miss at 0x2
        s_address = 32'h2; s_read = 1'b1;
        #1;
        chk("cold_swait", 32'(s_waitrequest), 1);
        tick;
        chk("cold_mread", 32'(m_read), 1);
        chk("cold_maddr", m_address, 32'h0);
        chk("cold_count", 32'(miss_count), 1);
        tick;
        chk("cold_wait_mread", 32'(m_read), 0);
        chk("cold_wait_swait", 32'(s_waitrequest), 1);
        m_readdata = 32'hBEEF_1234; m_readdatavalid = 1'b1;
        tick;
        m_readdatavalid = 1'b0;
        #1;
        chk("cold_hit_swait", 32'(s_waitrequest), 0);
        tick;
        chk("cold_rvalid", 32'(s_readdatavalid), 1);
        chk("cold_rdata", 32'(s_readdata), 32'hBEEF);
        chk("cold_rdata_swap", 32'(s_readdata1), 32'h1234);
        s_read = 1'b0;
        tick;
        chk("cold_rvalid_pulse", 32'(s_readdatavalid), 0);
        chk("cold_mcmds", 32'(mcmds), 1);
        // back-to-back hits
        s_address = 32'h0; s_read = 1'b1;
        #1;
        chk("hit_swait", 32'(s_waitrequest), 0);
        tick;
        chk("hit0_rvalid", 32'(s_readdatavalid), 1);
        chk("hit0_rdata", 32'(s_readdata), 32'h1234);
        chk("hit0_rdata_swap", 32'(s_readdata1), 32'hBEEF);
        s_address = 32'h2;
        tick;
        chk("hit1_rvalid", 32'(s_readdatavalid), 1);
        chk("hit1_rdata", 32'(s_readdata), 32'hBEEF);
        chk("hit1_rdata_swap", 32'(s_readdata1), 32'h1234);
        chk("hit_mread", 32'(m_read), 0);
        s_read = 1'b0;
        tick;
        chk("hit_rvalid_end", 32'(s_readdatavalid), 0);
        chk("hit_count", 32'(miss_count), 1);
        chk("hit_mcmds", 32'(mcmds), 1);
        // memory stall, with an illegal address change that must be ignored
        m_waitrequest = 1'b1; s_address = 32'h100; s_read = 1'b1;
        tick;
        for (int i = 0; i < 5; i++) begin
            chk("stall_mread", 32'(m_read), 1);
            chk("stall_maddr", m_address, 32'h100);
            chk("stall_swait", 32'(s_waitrequest), 1);
            s_address = 32'h200;
            tick;
        end
        m_waitrequest = 1'b0; s_address = 32'h100;
        #1;
        chk("stall_release_mread", 32'(m_read), 1);
        tick;
        chk("stall_wait_mread", 32'(m_read), 0);
        chk("stall_mcmds", 32'(mcmds), 2);
        m_readdata = 32'hCAFE_F00D; m_readdatavalid = 1'b1;
        tick;
        m_readdatavalid = 1'b0;
        #1;
        chk("stall_hit_swait", 32'(s_waitrequest), 0);
        tick;
        chk("stall_rdata", 32'(s_readdata), 32'hF00D);
        chk("stall_rdata_swap", 32'(s_readdata1), 32'hCAFE);
        chk("stall_count", 32'(miss_count), 2);
        s_read = 1'b0;
        tick;
        // flush collides with the fill
        s_address = 32'h306; s_read = 1'b1;
        #1;
        chk("flush_swait", 32'(s_waitrequest), 1);
        tick;
        tick;
        m_readdata = 32'h1111_2222; m_readdatavalid = 1'b1; flush = 1'b1;
        tick;
        m_readdatavalid = 1'b0; flush = 1'b0;
        #1;
        chk("flush_valid", 32'(dut.valid_q), 0);
        chk("flush_remiss", 32'(s_waitrequest), 1);
        tick;
        chk("flush_mread", 32'(m_read), 1);
        chk("flush_maddr", m_address, 32'h304);
        chk("flush_count", 32'(miss_count), 4);
        tick;
        chk("flush_mcmds", 32'(mcmds), 4);
        m_readdata = 32'h3333_4444; m_readdatavalid = 1'b1;
        tick;
        m_readdatavalid = 1'b0;
        tick;
        chk("flush_rvalid", 32'(s_readdatavalid), 1);
        chk("flush_rdata", 32'(s_readdata), 32'h3333);
        chk("flush_rdata_swap", 32'(s_readdata1), 32'h4444);
        s_read = 1'b0;
        tick;
        // reset while waiting for data, then a stray response
        s_address = 32'h400; s_read = 1'b1;
        tick;
        tick;
        rst_n = 1'b0;
        #1;
        chk("rstw_swait", 32'(s_waitrequest), 0);
        chk("rstw_mread", 32'(m_read), 0);
        chk("rstw_count", 32'(miss_count), 0);
        chk("rstw_rvalid", 32'(s_readdatavalid), 0);
        s_read = 1'b0;
        tick;
        rst_n = 1'b1;
        m_readdata = 32'h5555_6666; m_readdatavalid = 1'b1;
        tick;
        m_readdatavalid = 1'b0;
        chk("stray_valid", 32'(dut.valid_q), 0);
        tick;
        chk("stray_rvalid", 32'(s_readdatavalid), 0);
        s_address = 32'h400; s_read = 1'b1;
        #1;
        chk("stray_remiss", 32'(s_waitrequest), 1);
        tick;
        chk("stray_mread", 32'(m_read), 1);
        chk("stray_count", 32'(miss_count), 1);
        tick;
        m_readdata = 32'h7777_8888; m_readdatavalid = 1'b1;
        tick;
        m_readdatavalid = 1'b0;
        tick;
        chk("stray_rdata", 32'(s_readdata), 32'h8888);
        chk("stray_rdata_swap", 32'(s_readdata1), 32'h7777);
        s_read = 1'b0;
        tick;
        // saturation of the miss counter
        force dut.miss_q = 16'hFFFE;
        #1;
        release dut.miss_q;
        #1;
        chk("sat_preload", 32'(miss_count), 32'hFFFE);
        do_miss(32'h1000, 32'hA0A0_0001, 16'h0001, 16'hA0A0);
        do_miss(32'h1006, 32'hB1B1_0002, 16'hB1B1, 16'h0002);
        do_miss(32'h2000, 32'hC2C2_0003, 16'h0003, 16'hC2C2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
